// File: rtl/blackjack_pkg.sv
// Shared constants, state encoding and index-to-card mapping for the card dealer.
package blackjack_pkg;

    localparam int DECK_SIZE  = 52;
    localparam int SUIT_SIZE  = 13;
    localparam int FACE_VALUE = 10;

    // Galois feedback mask for taps 16,14,13,11 (right-shifting form).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Fixed-width copies of the deck constants.
    localparam logic [5:0] DECK_SIZE_6 = 6'd52;
    localparam logic [5:0] LAST_IDX_6  = 6'd51;

    typedef enum logic [1:0] {
        DLR_IDLE   = 2'd0,
        DLR_SEARCH = 2'd1,
        DLR_DONE   = 2'd2
    } dlr_state_t;

    // Fold a raw 6-bit random value (0..63) into the deck range 0..51.
    function automatic logic [5:0] wrap_idx(input logic [5:0] raw);
        return (raw >= DECK_SIZE_6) ? (raw - DECK_SIZE_6) : raw;
    endfunction

    // Suit is the deck index divided by 13, done as a compare chain.
    function automatic logic [1:0] idx_to_suit(input logic [5:0] idx);
        if (idx >= 6'd39)      return 2'd3;
        else if (idx >= 6'd26) return 2'd2;
        else if (idx >= 6'd13) return 2'd1;
        else                   return 2'd0;
    endfunction

    // Rank is (index mod 13) + 1, done as a compare/subtract chain.
    function automatic logic [3:0] idx_to_rank(input logic [5:0] idx);
        logic [5:0] rem;
        rem = idx;
        if (idx >= 6'd39)      rem = idx - 6'd39;
        else if (idx >= 6'd26) rem = idx - 6'd26;
        else if (idx >= 6'd13) rem = idx - 6'd13;
        return rem[3:0] + 4'd1;
    endfunction

    // BlackJack value: ace counts 1 here, picture cards count 10.
    function automatic logic [3:0] rank_to_value(input logic [3:0] rank);
        return (rank > 4'(FACE_VALUE)) ? 4'(FACE_VALUE) : rank;
    endfunction

endpackage

// File: rtl/card_dealer_lfsr16.sv
// Free-running Galois LFSR; falls back to the seed if it ever reaches zero.
module lfsr16
    import blackjack_pkg::*;
#(
    parameter int              LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [5:0] sample
);

    logic [LFSR_W-1:0] lfsr;

    // Advance every cycle; a zero state would lock up, so reload the seed instead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED;
        end else if (lfsr == '0) begin
            lfsr <= SEED;
        end else if (lfsr[0]) begin
            lfsr <= (lfsr >> 1) ^ LFSR_TAPS[LFSR_W-1:0];
        end else begin
            lfsr <= lfsr >> 1;
        end
    end

    assign sample = lfsr[5:0];

endmodule

// File: rtl/card_dealer.sv
// Deals cards without repetition from a single 52-card deck.
// Handshake: a one-cycle i_Req pulse is accepted only in IDLE with cards left;
// o_Busy then stays high until and including the single o_Valid cycle, and
// requests seen while busy are dropped. i_Shuffle overrides everything.
module card_dealer
    import blackjack_pkg::*;
#(
    parameter int               LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED  = 16'hACE1
) (
    input  logic       inclk0,
    input  logic       i_Reset,
    input  logic       i_Shuffle,
    input  logic       i_Req,
    output logic       o_Busy,
    output logic       o_Valid,
    output logic [3:0] o_Card,
    output logic [3:0] o_Rank,
    output logic [1:0] o_Suit,
    output logic [5:0] o_CardsLeft,
    output logic       o_DeckEmpty,
    output logic [1:0] dbg_state
);

    dlr_state_t  state;
    dlr_state_t  state_next;
    logic [51:0] mask;
    logic [5:0]  idx;
    logic [5:0]  cards_left;
    logic [3:0]  card_r;
    logic [3:0]  rank_r;
    logic [1:0]  suit_r;
    logic [5:0]  lfsr_sample;

    logic        load_idx;
    logic        step_idx;
    logic        take_card;
    logic        clear_deck;

    lfsr16 #(
        .LFSR_W (LFSR_W),
        .SEED   (SEED)
    ) u_lfsr (
        .clk    (inclk0),
        .rst_n  (i_Reset),
        .sample (lfsr_sample)
    );

    // State register.
    always_ff @(posedge inclk0 or negedge i_Reset) begin
        if (!i_Reset) begin
            state <= DLR_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath controls; shuffle aborts any draw in progress.
    always_comb begin
        state_next = state;
        load_idx   = 1'b0;
        step_idx   = 1'b0;
        take_card  = 1'b0;
        clear_deck = i_Shuffle;
        if (i_Shuffle) begin
            state_next = DLR_IDLE;
        end else begin
            case (state)
                DLR_IDLE: begin
                    if (i_Req && (cards_left != 6'd0)) begin
                        load_idx   = 1'b1;
                        state_next = DLR_SEARCH;
                    end
                end
                DLR_SEARCH: begin
                    if (mask[idx]) begin
                        step_idx = 1'b1;
                    end else begin
                        take_card  = 1'b1;
                        state_next = DLR_DONE;
                    end
                end
                DLR_DONE: begin
                    state_next = DLR_IDLE;
                end
                default: begin
                    state_next = DLR_IDLE;
                end
            endcase
        end
    end

    // Probe index: random start, then linear walk with wrap at the deck end.
    always_ff @(posedge inclk0 or negedge i_Reset) begin
        if (!i_Reset) begin
            idx <= 6'd0;
        end else if (load_idx) begin
            idx <= wrap_idx(lfsr_sample);
        end else if (step_idx) begin
            idx <= (idx == LAST_IDX_6) ? 6'd0 : idx + 6'd1;
        end
    end

    // Deck mask and remaining-card counter.
    always_ff @(posedge inclk0 or negedge i_Reset) begin
        if (!i_Reset) begin
            mask       <= '0;
            cards_left <= DECK_SIZE_6;
        end else if (clear_deck) begin
            mask       <= '0;
            cards_left <= DECK_SIZE_6;
        end else if (take_card) begin
            mask[idx]  <= 1'b1;
            cards_left <= cards_left - 6'd1;
        end
    end

    // Card outputs are captured on the winning probe and held until the next draw.
    always_ff @(posedge inclk0 or negedge i_Reset) begin
        if (!i_Reset) begin
            card_r <= 4'd0;
            rank_r <= 4'd0;
            suit_r <= 2'd0;
        end else if (take_card) begin
            rank_r <= idx_to_rank(idx);
            card_r <= rank_to_value(idx_to_rank(idx));
            suit_r <= idx_to_suit(idx);
        end
    end

    assign o_Busy      = (state != DLR_IDLE);
    assign o_Valid     = (state == DLR_DONE);
    assign o_Card      = card_r;
    assign o_Rank      = rank_r;
    assign o_Suit      = suit_r;
    assign o_CardsLeft = cards_left;
    assign o_DeckEmpty = (cards_left == 6'd0);
    assign dbg_state   = state;

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: full-deck deal, empty deck, busy, shuffle and reset cases.
module tb_card_dealer;
    import blackjack_pkg::*;

    logic       inclk0;
    logic       i_Reset;
    logic       i_Shuffle;
    logic       i_Req;
    logic       o_Busy;
    logic       o_Valid;
    logic [3:0] o_Card;
    logic [3:0] o_Rank;
    logic [1:0] o_Suit;
    logic [5:0] o_CardsLeft;
    logic       o_DeckEmpty;
    logic [1:0] dbg_state;

    int tests;
    int fails;

    card_dealer dut (
        .inclk0      (inclk0),
        .i_Reset     (i_Reset),
        .i_Shuffle   (i_Shuffle),
        .i_Req       (i_Req),
        .o_Busy      (o_Busy),
        .o_Valid     (o_Valid),
        .o_Card      (o_Card),
        .o_Rank      (o_Rank),
        .o_Suit      (o_Suit),
        .o_CardsLeft (o_CardsLeft),
        .o_DeckEmpty (o_DeckEmpty),
        .dbg_state   (dbg_state)
    );

    // Clock.
    initial inclk0 = 1'b0;
    always #5 inclk0 = ~inclk0;

    // Hard time limit so the run can never hang.
    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse a request and wait (bounded) for o_Valid; returns at the valid cycle.
    task automatic draw(output int lat, output logic ok);
        @(negedge inclk0);
        i_Req = 1'b1;
        @(negedge inclk0);
        i_Req = 1'b0;
        lat = 1;
        check("draw_busy_after_req", 32'(o_Busy), 32'd1);
        while (o_Valid !== 1'b1 && lat < 60) begin
            @(negedge inclk0);
            lat++;
        end
        ok = (o_Valid === 1'b1);
    endtask

    // Count o_Valid and o_Busy highs over n cycles.
    task automatic watch(input int n, output int valids, output int busys);
        valids = 0;
        busys  = 0;
        for (int k = 0; k < n; k++) begin
            if (o_Valid === 1'b1) valids++;
            if (o_Busy === 1'b1) busys++;
            @(negedge inclk0);
        end
    endtask

    initial begin
        int         lat;
        logic       ok;
        int         nv;
        int         nb;
        logic [3:0] exp_card;
        logic [3:0] held_rank;
        logic       seen [0:51];
        int         slot;

        tests     = 0;
        fails     = 0;
        i_Reset   = 1'b0;
        i_Shuffle = 1'b0;
        i_Req     = 1'b0;
        for (int s = 0; s < 52; s++) seen[s] = 1'b0;

        // 1. Reset values, then idle for 100 cycles.
        repeat (3) @(negedge inclk0);
        check("rst_cards_left", 32'(o_CardsLeft), 32'd52);
        check("rst_valid", 32'(o_Valid), 32'd0);
        check("rst_busy", 32'(o_Busy), 32'd0);
        check("rst_card", 32'(o_Card), 32'd0);
        check("rst_rank", 32'(o_Rank), 32'd0);
        check("rst_suit", 32'(o_Suit), 32'd0);
        check("rst_deck_empty", 32'(o_DeckEmpty), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(DLR_IDLE));
        i_Reset = 1'b1;
        watch(100, nv, nb);
        check("idle_no_valid", 32'(nv), 32'd0);
        check("idle_no_busy", 32'(nb), 32'd0);
        check("idle_cards_left", 32'(o_CardsLeft), 32'd52);
        check("idle_deck_empty", 32'(o_DeckEmpty), 32'd0);

        // 2. Deal the whole deck; every card must appear exactly once.
        for (int n = 0; n < 52; n++) begin
            draw(lat, ok);
            check("deal_valid", 32'(ok), 32'd1);
            check("deal_latency_le53", 32'(lat <= 53), 32'd1);
            check("deal_rank_range", 32'((o_Rank >= 4'd1) && (o_Rank <= 4'd13)), 32'd1);
            exp_card = (o_Rank > 4'd10) ? 4'd10 : o_Rank;
            check("deal_card_value", 32'(o_Card), 32'(exp_card));
            slot = int'(o_Suit) * 13 + int'(o_Rank) - 1;
            if (slot < 0 || slot > 51) slot = 0;
            check("deal_unique", 32'(seen[slot]), 32'd0);
            seen[slot] = 1'b1;
            check("deal_cards_left", 32'(o_CardsLeft), 32'(51 - n));
            check("deal_deck_empty", 32'(o_DeckEmpty), 32'(n == 51));
        end
        held_rank = o_Rank;
        @(negedge inclk0);
        check("post_deal_valid_pulse", 32'(o_Valid), 32'd0);
        check("post_deal_busy", 32'(o_Busy), 32'd0);
        check("post_deal_rank_held", 32'(o_Rank), 32'(held_rank));
        check("post_deal_cards_left", 32'(o_CardsLeft), 32'd0);
        check("post_deal_deck_empty", 32'(o_DeckEmpty), 32'd1);

        // 3. Request on an empty deck is ignored; shuffle restores the deck.
        i_Req = 1'b1;
        @(negedge inclk0);
        i_Req = 1'b0;
        watch(60, nv, nb);
        check("empty_no_valid", 32'(nv), 32'd0);
        check("empty_no_busy", 32'(nb), 32'd0);
        check("empty_deck_empty", 32'(o_DeckEmpty), 32'd1);
        i_Shuffle = 1'b1;
        @(negedge inclk0);
        i_Shuffle = 1'b0;
        check("shuf_cards_left", 32'(o_CardsLeft), 32'd52);
        check("shuf_deck_empty", 32'(o_DeckEmpty), 32'd0);
        draw(lat, ok);
        check("shuf_draw_valid", 32'(ok), 32'd1);
        check("shuf_draw_cards_left", 32'(o_CardsLeft), 32'd51);

        // 4. Second request while busy is dropped.
        @(negedge inclk0);
        i_Req = 1'b1;
        @(negedge inclk0);
        check("busy_req_busy", 32'(o_Busy), 32'd1);
        @(negedge inclk0);
        i_Req = 1'b0;
        watch(70, nv, nb);
        check("busy_one_valid", 32'(nv), 32'd1);
        check("busy_cards_left", 32'(o_CardsLeft), 32'd50);
        check("busy_final_idle", 32'(o_Busy), 32'd0);

        // 5. Shuffle aborts a search after 40 cards are out.
        for (int n = 0; n < 38; n++) begin
            draw(lat, ok);
            check("bulk_valid", 32'(ok), 32'd1);
        end
        check("bulk_cards_left", 32'(o_CardsLeft), 32'd12);
        @(negedge inclk0);
        i_Req = 1'b1;
        @(negedge inclk0);
        i_Req     = 1'b0;
        i_Shuffle = 1'b1;
        check("abort_no_valid_yet", 32'(o_Valid), 32'd0);
        @(negedge inclk0);
        i_Shuffle = 1'b0;
        check("abort_no_valid", 32'(o_Valid), 32'd0);
        check("abort_cards_left", 32'(o_CardsLeft), 32'd52);
        check("abort_busy", 32'(o_Busy), 32'd0);
        watch(60, nv, nb);
        check("abort_later_no_valid", 32'(nv), 32'd0);
        i_Shuffle = 1'b1;
        i_Req     = 1'b1;
        @(negedge inclk0);
        i_Shuffle = 1'b0;
        i_Req     = 1'b0;
        check("both_busy", 32'(o_Busy), 32'd0);
        check("both_cards_left", 32'(o_CardsLeft), 32'd52);
        watch(20, nv, nb);
        check("both_no_valid", 32'(nv), 32'd0);
        check("both_no_busy", 32'(nb), 32'd0);
        check("both_cards_left_after", 32'(o_CardsLeft), 32'd52);

        // 6. Asynchronous reset during a search.
        for (int n = 0; n < 3; n++) begin
            draw(lat, ok);
            check("pre_rst_valid", 32'(ok), 32'd1);
        end
        @(negedge inclk0);
        check("pre_rst_cards_left", 32'(o_CardsLeft), 32'd49);
        i_Req = 1'b1;
        @(negedge inclk0);
        i_Req = 1'b0;
        check("mid_search_state", 32'(dbg_state), 32'(DLR_SEARCH));
        #1;
        i_Reset = 1'b0;
        #1;
        check("async_busy", 32'(o_Busy), 32'd0);
        check("async_valid", 32'(o_Valid), 32'd0);
        check("async_cards_left", 32'(o_CardsLeft), 32'd52);
        check("async_card", 32'(o_Card), 32'd0);
        check("async_rank", 32'(o_Rank), 32'd0);
        check("async_suit", 32'(o_Suit), 32'd0);
        check("async_deck_empty", 32'(o_DeckEmpty), 32'd0);
        check("async_state", 32'(dbg_state), 32'(DLR_IDLE));
        @(negedge inclk0);
        i_Reset = 1'b1;
        watch(30, nv, nb);
        check("post_rst_no_valid", 32'(nv), 32'd0);
        check("post_rst_no_busy", 32'(nb), 32'd0);
        check("post_rst_cards_left", 32'(o_CardsLeft), 32'd52);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
